// File: rtl/card_request_arbiter.sv
// Round-robin arbiter sharing one random card source between player and dealer FSMs.
// Issues card requests, range-checks returned cards with bounded retry, and counts cards dealt.
module card_request_arbiter #(
    parameter int CARD_LAT  = 2,
    parameter int CARD_MIN  = 1,
    parameter int CARD_MAX  = 13,
    parameter int MAX_RETRY = 4,
    parameter int DECK_SIZE = 52,
    parameter int CNT_W     = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             p_req_i,
    input  logic             d_req_i,
    input  logic             new_deck_i,
    input  logic [7:0]       card_i,
    output logic             request_card_o,
    output logic             p_ack_o,
    output logic             d_ack_o,
    output logic [7:0]       card_o,
    output logic             err_o,
    output logic             busy_o,
    output logic             deck_empty_o,
    output logic [CNT_W-1:0] cards_dealt_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int WAIT_W  = (CARD_LAT > 1) ? $clog2(CARD_LAT) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    logic [2:0]         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               win_d;
    logic               last_d;
    logic               err_r;
    logic [7:0]         card_r;
    logic [CNT_W-1:0]   dealt;
    logic               card_ok;

    assign card_ok = (card_r >= 8'(CARD_MIN)) && (card_r <= 8'(CARD_MAX));

    // last_d=1 after reset so a simultaneous first request goes to the player
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            win_d     <= 1'b0;
            last_d    <= 1'b1;
            err_r     <= 1'b0;
            card_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!deck_empty_o && (p_req_i || d_req_i)) begin
                        win_d     <= d_req_i && (!p_req_i || !last_d);
                        retry_cnt <= '0;
                        err_r     <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(CARD_LAT - 1)) begin
                        card_r <= card_i;
                        state  <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (card_ok) begin
                        err_r <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
                            err_r <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    last_d <= win_d;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A new deck clears the count even when it lands on a completing deal
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dealt <= '0;
        end else if (new_deck_i) begin
            dealt <= '0;
        end else if (state == S_DONE && !err_r && dealt != CNT_W'(DECK_SIZE)) begin
            dealt <= dealt + 1'b1;
        end
    end

    assign request_card_o = (state == S_ISSUE);
    assign p_ack_o        = (state == S_DONE) && !win_d;
    assign d_ack_o        = (state == S_DONE) && win_d;
    assign err_o          = (state == S_DONE) && err_r;
    assign card_o         = card_r;
    assign busy_o         = (state != S_IDLE);
    assign deck_empty_o   = (dealt == CNT_W'(DECK_SIZE));
    assign cards_dealt_o  = dealt;

endmodule

// File: tb/tb_card_request_arbiter.sv
// Self-checking bench for card_request_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of arbitration, retry and counting.
module tb_card_request_arbiter;

    localparam int CARD_LAT  = 2;
    localparam int CARD_MIN  = 1;
    localparam int CARD_MAX  = 13;
    localparam int MAX_RETRY = 4;
    localparam int DECK_SIZE = 52;
    localparam int CNT_W     = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             p_req;
    logic             d_req;
    logic             new_deck;
    logic [7:0]       card_i;
    logic             request_card;
    logic             p_ack;
    logic             d_ack;
    logic [7:0]       card_o;
    logic             err_o;
    logic             busy;
    logic             deck_empty;
    logic [CNT_W-1:0] cards_dealt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int   model_dealt = 0;
    logic model_last_d = 1'b1;

    card_request_arbiter #(
        .CARD_LAT (CARD_LAT),
        .CARD_MIN (CARD_MIN),
        .CARD_MAX (CARD_MAX),
        .MAX_RETRY(MAX_RETRY),
        .DECK_SIZE(DECK_SIZE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .p_req_i       (p_req),
        .d_req_i       (d_req),
        .new_deck_i    (new_deck),
        .card_i        (card_i),
        .request_card_o(request_card),
        .p_ack_o       (p_ack),
        .d_ack_o       (d_ack),
        .card_o        (card_o),
        .err_o         (err_o),
        .busy_o        (busy),
        .deck_empty_o  (deck_empty),
        .cards_dealt_o (cards_dealt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Card source: presents the queued value only around the capture edge, 0xEE otherwise
    logic [7:0] card_q[$];
    logic [7:0] next_card = 8'h00;
    int         pend = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend   <= 0;
            card_i <= 8'hEE;
        end else if (request_card) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
            if (card_q.size() > 0) next_card <= card_q.pop_front();
            else next_card <= 8'($urandom_range(CARD_MIN, CARD_MAX));
            pend   <= CARD_LAT;
            card_i <= 8'hEE;
        end else if (pend > 0) begin
            pend   <= pend - 1;
            card_i <= (pend == 1) ? next_card : 8'hEE;
        end else begin
            card_i <= 8'hEE;
        end
    end

    logic inv_bad = 1'b0;
    always @(negedge clk) begin
        if (!rst && ((p_ack && d_ack) || (request_card && !busy) || ((p_ack || d_ack) && !busy)))
            inv_bad <= 1'b1;
    end

    function automatic void model_txn(input logic [7:0] seq[$], output int pulses,
                                      output logic err, output logic [7:0] last);
        pulses = 0;
        err    = 1'b1;
        last   = 8'h00;
        for (int i = 0; i < MAX_RETRY; i++) begin
            pulses++;
            last = seq[i];
            if (seq[i] >= CARD_MIN && seq[i] <= CARD_MAX) begin
                err = 1'b0;
                break;
            end
        end
    endfunction

    task automatic wait_ack(input int maxc, output logic got, output logic who_d, output int at);
        got = 1'b0; who_d = 1'b0; at = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (p_ack || d_ack) begin
                got = 1'b1; who_d = d_ack; at = cyc;
            end
        end
    endtask

    task automatic run_txn(input logic use_p, input logic use_d, output logic got,
                           output logic who_d, output int t0, output int lat,
                           output int pulses, output logic [7:0] card, output logic err);
        int p0, at;
        @(posedge clk); #1;
        p0 = pulse_cnt; p_req = use_p; d_req = use_d; t0 = cyc;
        wait_ack(80, got, who_d, at);
        lat = at - t0; pulses = pulse_cnt - p0; card = card_o; err = err_o;
        @(posedge clk); #1;
        p_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic pulse_new_deck();
        @(posedge clk); #1; new_deck = 1'b1;
        @(posedge clk); #1; new_deck = 1'b0;
        model_dealt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; p_req = 1'b0; d_req = 1'b0; new_deck = 1'b0;
        repeat (3) @(negedge clk);
        tests += 7;
        if (request_card !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", request_card); end
        if (p_ack !== 1'b0) begin fails++; $display("FAIL reset_pack: got %b want 0", p_ack); end
        if (d_ack !== 1'b0) begin fails++; $display("FAIL reset_dack: got %b want 0", d_ack); end
        if (card_o !== 8'h00) begin fails++; $display("FAIL reset_card: got %h want 00", card_o); end
        if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_o); end
        if (busy !== 1'b0 || deck_empty !== 1'b0) begin fails++; $display("FAIL reset_busy_empty: got %b%b want 00", busy, deck_empty); end
        if (cards_dealt !== '0) begin fails++; $display("FAIL reset_dealt: got %0d want 0", cards_dealt); end
        @(posedge clk); #1; rst = 1'b0;
        model_dealt = 0; model_last_d = 1'b1;
    endtask

    task automatic test_single();
        logic got, who, err; int t0, lat, pulses; logic [7:0] card;
        card_q.delete(); card_q.push_back(8'd7);
        run_txn(1'b1, 1'b0, got, who, t0, lat, pulses, card, err);
        model_dealt++; model_last_d = 1'b0;
        tests += 7;
        if (!got || who !== 1'b0) begin fails++; $display("FAIL single_ack: got=%b who_d=%b want player ack", got, who); end
        if (lat !== CARD_LAT + 3) begin fails++; $display("FAIL single_lat: got %0d want %0d", lat, CARD_LAT + 3); end
        if (pulses !== 1) begin fails++; $display("FAIL single_pulses: got %0d want 1", pulses); end
        if (last_pulse_cyc !== t0 + 1) begin fails++; $display("FAIL single_pulse_cyc: got %0d want %0d", last_pulse_cyc, t0 + 1); end
        if (card !== 8'd7) begin fails++; $display("FAIL single_card: got %0d want 7", card); end
        if (err !== 1'b0) begin fails++; $display("FAIL single_err: got %b want 0", err); end
        if (cards_dealt !== CNT_W'(model_dealt)) begin fails++; $display("FAIL single_dealt: got %0d want %0d", cards_dealt, model_dealt); end
    endtask

    task automatic test_round_robin();
        logic got, who; int at, prev;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        model_dealt = 0; model_last_d = 1'b1;
        card_q.delete();
        @(posedge clk); #1; p_req = 1'b1; d_req = 1'b1; prev = cyc - 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(40, got, who, at);
            tests += 2;
            if (!got || who !== !model_last_d) begin fails++; $display("FAIL rr_order%0d: got=%b who_d=%b want who_d=%b", k, got, who, !model_last_d); end
            if (at - prev !== CARD_LAT + 4) begin fails++; $display("FAIL rr_gap%0d: got %0d want %0d", k, at - prev, CARD_LAT + 4); end
            model_last_d = !model_last_d; model_dealt++; prev = at;
        end
        @(posedge clk); #1; p_req = 1'b0; d_req = 1'b0;
        tests++;
        if (cards_dealt !== CNT_W'(model_dealt)) begin fails++; $display("FAIL rr_dealt: got %0d want %0d", cards_dealt, model_dealt); end
    endtask

    task automatic test_retry();
        logic got, who, err; int t0, lat, pulses; logic [7:0] card;
        card_q.delete(); card_q.push_back(8'd0); card_q.push_back(8'd14); card_q.push_back(8'd5);
        run_txn(1'b0, 1'b1, got, who, t0, lat, pulses, card, err);
        model_dealt++; model_last_d = 1'b1;
        tests += 5;
        if (!got || who !== 1'b1) begin fails++; $display("FAIL retry_ack: got=%b who_d=%b want dealer ack", got, who); end
        if (pulses !== 3) begin fails++; $display("FAIL retry_pulses: got %0d want 3", pulses); end
        if (lat !== CARD_LAT + 3 + 2 * (CARD_LAT + 2)) begin fails++; $display("FAIL retry_lat: got %0d want %0d", lat, CARD_LAT + 3 + 2 * (CARD_LAT + 2)); end
        if (card !== 8'd5 || err !== 1'b0) begin fails++; $display("FAIL retry_card: got %0d err %b want 5 err 0", card, err); end
        if (cards_dealt !== CNT_W'(model_dealt)) begin fails++; $display("FAIL retry_dealt: got %0d want %0d", cards_dealt, model_dealt); end
    endtask

    task automatic test_give_up();
        logic got, who, err; int t0, lat, pulses; logic [7:0] card;
        card_q.delete();
        for (int i = 0; i < MAX_RETRY; i++) card_q.push_back(8'hFF);
        run_txn(1'b1, 1'b0, got, who, t0, lat, pulses, card, err);
        model_last_d = 1'b0;
        card_q.delete();
        tests += 5;
        if (!got || who !== 1'b0) begin fails++; $display("FAIL giveup_ack: got=%b who_d=%b want player ack", got, who); end
        if (pulses !== MAX_RETRY) begin fails++; $display("FAIL giveup_pulses: got %0d want %0d", pulses, MAX_RETRY); end
        if (lat !== CARD_LAT + 3 + (MAX_RETRY - 1) * (CARD_LAT + 2)) begin fails++; $display("FAIL giveup_lat: got %0d want %0d", lat, CARD_LAT + 3 + (MAX_RETRY - 1) * (CARD_LAT + 2)); end
        if (err !== 1'b1 || card !== 8'hFF) begin fails++; $display("FAIL giveup_err: got err %b card %h want err 1 card ff", err, card); end
        if (cards_dealt !== CNT_W'(model_dealt)) begin fails++; $display("FAIL giveup_dealt: got %0d want %0d", cards_dealt, model_dealt); end
    endtask

    task automatic test_random();
        logic got, who, err, exp_err, exp_who; int t0, lat, pulses, exp_pulses, sel;
        logic [7:0] card, exp_card;
        logic [7:0] seq[$];
        pulse_new_deck();
        tests++;
        if (cards_dealt !== '0) begin fails++; $display("FAIL rand_newdeck: got %0d want 0", cards_dealt); end
        for (int n = 0; n < 30; n++) begin
            seq.delete();
            for (int i = 0; i < MAX_RETRY; i++) begin
                if ($urandom_range(0, 2) == 0)
                    seq.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(CARD_MAX + 1, 255)));
                else
                    seq.push_back(8'($urandom_range(CARD_MIN, CARD_MAX)));
            end
            model_txn(seq, exp_pulses, exp_err, exp_card);
            sel = $urandom_range(0, 2);
            exp_who = (sel == 0) ? 1'b0 : (sel == 1) ? 1'b1 : !model_last_d;
            card_q = seq;
            run_txn(sel != 1, sel != 0, got, who, t0, lat, pulses, card, err);
            card_q.delete();
            model_last_d = exp_who;
            if (!exp_err && model_dealt < DECK_SIZE) model_dealt++;
            tests += 4;
            if (!got || who !== exp_who) begin fails++; $display("FAIL rand%0d_who: got=%b who_d=%b want %b", n, got, who, exp_who); end
            if (lat !== CARD_LAT + 3 + (exp_pulses - 1) * (CARD_LAT + 2) || pulses !== exp_pulses) begin
                fails++; $display("FAIL rand%0d_timing: got lat %0d pulses %0d want lat %0d pulses %0d", n, lat, pulses, CARD_LAT + 3 + (exp_pulses - 1) * (CARD_LAT + 2), exp_pulses);
            end
            if (card !== exp_card || err !== exp_err) begin fails++; $display("FAIL rand%0d_card: got %0d err %b want %0d err %b", n, card, err, exp_card, exp_err); end
            if (cards_dealt !== CNT_W'(model_dealt)) begin fails++; $display("FAIL rand%0d_dealt: got %0d want %0d", n, cards_dealt, model_dealt); end
        end
    endtask

    task automatic test_deck_empty();
        logic got, who, err, saw; int t0, lat, pulses, t1, at; logic [7:0] card;
        pulse_new_deck();
        card_q.delete();
        while (model_dealt < DECK_SIZE) begin
            run_txn(1'b1, 1'b0, got, who, t0, lat, pulses, card, err);
            if (!got) break;
            model_dealt++;
        end
        model_last_d = 1'b0;
        tests += 2;
        if (cards_dealt !== CNT_W'(DECK_SIZE)) begin fails++; $display("FAIL empty_count: got %0d want %0d", cards_dealt, DECK_SIZE); end
        if (deck_empty !== 1'b1) begin fails++; $display("FAIL empty_flag: got %b want 1", deck_empty); end
        @(posedge clk); #1; d_req = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (p_ack || d_ack || busy) saw = 1'b1;
        end
        tests++;
        if (saw !== 1'b0) begin fails++; $display("FAIL empty_blocked: got activity %b want 0", saw); end
        @(posedge clk); #1; new_deck = 1'b1; t1 = cyc;
        @(posedge clk); #1; new_deck = 1'b0;
        wait_ack(40, got, who, at);
        @(posedge clk); #1; d_req = 1'b0;
        model_dealt = 1; model_last_d = 1'b1;
        tests += 3;
        if (!got || who !== 1'b1) begin fails++; $display("FAIL empty_served: got=%b who_d=%b want dealer ack", got, who); end
        if (at - t1 !== CARD_LAT + 4) begin fails++; $display("FAIL empty_served_lat: got %0d want %0d", at - t1, CARD_LAT + 4); end
        if (cards_dealt !== CNT_W'(model_dealt) || deck_empty !== 1'b0) begin fails++; $display("FAIL empty_after: got %0d/%b want %0d/0", cards_dealt, deck_empty, model_dealt); end
    endtask

    task automatic test_reset_mid();
        logic got, who, saw; int at;
        card_q.delete();
        @(posedge clk); #1; p_req = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        tests += 2;
        if (busy !== 1'b0 || request_card !== 1'b0 || p_ack !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: got busy %b req %b ack %b want 000", busy, request_card, p_ack); end
        if (card_o !== 8'h00 || cards_dealt !== '0) begin fails++; $display("FAIL midrst_data: got card %h dealt %0d want 00/0", card_o, cards_dealt); end
        p_req = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        model_dealt = 0; model_last_d = 1'b1;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (p_ack || d_ack || busy) saw = 1'b1;
        end
        tests++;
        if (saw !== 1'b0) begin fails++; $display("FAIL midrst_noack: got activity %b want 0", saw); end
        @(posedge clk); #1; p_req = 1'b1;
        wait_ack(40, got, who, at);
        new_deck = 1'b1;
        @(posedge clk); #1; new_deck = 1'b0; p_req = 1'b0;
        model_dealt = 0; model_last_d = 1'b0;
        tests += 2;
        if (!got) begin fails++; $display("FAIL clearwin_ack: got %b want 1", got); end
        if (cards_dealt !== '0) begin fails++; $display("FAIL clearwin_dealt: got %0d want 0", cards_dealt); end
    endtask

    task automatic test_invariants();
        tests++;
        if (inv_bad !== 1'b0) begin fails++; $display("FAIL invariants: got violation %b want 0", inv_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_retry();
        test_give_up();
        test_random();
        test_deck_empty();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
